// File: rtl/vsa_dmem.sv
// vsa_dmem: data-memory stage for the 12-bit VSA core (32 x 5-bit array).
// Stores are posted through a write queue with store-to-load forwarding.
//
// Ports:
//   clock, reset_n           master clock, async active-low reset
//   addr, wdata, wr          core address, store data, store strobe
//   rdata                    combinational load data
//   ld_valid/ld_addr/ld_data loader write port (priority over draining)
//   count, empty, full       write-queue occupancy
//   overflow                 sticky: a store was dropped on a full queue
module vsa_dmem #(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [4:0]               addr,
    input  logic [4:0]               wdata,
    input  logic                     wr,
    output logic [4:0]               rdata,
    input  logic                     ld_valid,
    input  logic [4:0]               ld_addr,
    input  logic [4:0]               ld_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [4:0]    mem    [32];
    logic [4:0]    q_addr [DEPTH];
    logic [4:0]    q_data [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   cnt;
    logic          ovf;

    logic          pop;
    logic          push;
    logic          fwd_hit;
    logic [4:0]    fwd_data;
    logic [PW-1:0] fwd_idx;

    // The loader owns the array write port, so it suppresses the drain.
    assign pop  = (cnt != '0) && !ld_valid;
    // A full queue still accepts a store if an entry leaves this cycle.
    assign push = wr && ((cnt != CNT_FULL) || pop);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= '0;
            end
        end else if (ld_valid) begin
            mem[ld_addr] <= ld_data;
        end else if (pop) begin
            mem[q_addr[head]] <= q_data[head];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_addr[i] <= '0;
                q_data[i] <= '0;
            end
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            if (push) begin
                q_addr[tail] <= addr;
                q_data[tail] <= wdata;
                tail         <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                cnt <= cnt + 1'b1;
            end else if (pop && !push) begin
                cnt <= cnt - 1'b1;
            end
            if (wr && !push) begin
                ovf <= 1'b1;
            end
        end
    end

    // Walk entries oldest to youngest starting at head, so the last
    // match is the youngest regardless of where the pointers wrapped.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (((PW+1)'(i) < cnt) && (q_addr[fwd_idx] == addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = q_data[fwd_idx];
            end
        end
    end

    assign rdata    = fwd_hit ? fwd_data : mem[addr];
    assign count    = cnt;
    assign empty    = (cnt == '0);
    assign full     = (cnt == CNT_FULL);
    assign overflow = ovf;

endmodule

// File: tb/tb_vsa_dmem.sv
// Testbench for vsa_dmem: directed stimulus with a scoreboard of expected
// output values, checked by a monitor on the falling clock edge.
module tb_vsa_dmem;

    localparam int DEPTH = 2;
    localparam int S_RDATA = 0;
    localparam int S_COUNT = 1;
    localparam int S_EMPTY = 2;
    localparam int S_FULL  = 3;
    localparam int S_OVF   = 4;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] addr;
    logic [4:0] wdata;
    logic       wr;
    logic [4:0] rdata;
    logic       ld_valid;
    logic [4:0] ld_addr;
    logic [4:0] ld_data;
    logic [$clog2(DEPTH):0] count;
    logic       empty;
    logic       full;
    logic       overflow;

    int tests = 0;
    int failed = 0;

    string q_name [$];
    int    q_sig  [$];
    int    q_exp  [$];

    string m_name;
    int    m_sig;
    int    m_exp;
    int    m_act;

    vsa_dmem #(.DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .addr     (addr),
        .wdata    (wdata),
        .wr       (wr),
        .rdata    (rdata),
        .ld_valid (ld_valid),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clock = ~clock;

    task automatic exp_push(input string n, input int s, input int v);
        q_name.push_back(n);
        q_sig.push_back(s);
        q_exp.push_back(v);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Monitor: compare every queued expectation against the live outputs.
    always @(negedge clock) begin
        while (q_sig.size() > 0) begin
            m_name = q_name.pop_front();
            m_sig  = q_sig.pop_front();
            m_exp  = q_exp.pop_front();
            case (m_sig)
                S_RDATA: m_act = int'(rdata);
                S_COUNT: m_act = int'(count);
                S_EMPTY: m_act = int'(empty);
                S_FULL:  m_act = int'(full);
                default: m_act = int'(overflow);
            endcase
            tests++;
            if (m_act != m_exp) begin
                failed++;
                $display("FAIL %s: got %0d expected %0d", m_name, m_act, m_exp);
            end
        end
    end

    initial begin
        reset_n  = 1'b0;
        addr     = '0;
        wdata    = '0;
        wr       = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;
        ld_data  = '0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Reset state
        addr = 5'd7;
        exp_push("rst_rdata", S_RDATA, 0);
        exp_push("rst_empty", S_EMPTY, 1);
        exp_push("rst_full",  S_FULL,  0);
        exp_push("rst_count", S_COUNT, 0);
        exp_push("rst_ovf",   S_OVF,   0);
        step();

        // Store then load
        wr = 1'b1; addr = 5'd5; wdata = 5'h13;
        step();
        wr = 1'b0;
        exp_push("sl_count1", S_COUNT, 1);
        exp_push("sl_fwd",    S_RDATA, 'h13);
        exp_push("sl_empty0", S_EMPTY, 0);
        step();
        exp_push("sl_count0", S_COUNT, 0);
        exp_push("sl_mem",    S_RDATA, 'h13);
        exp_push("sl_empty1", S_EMPTY, 1);
        step();

        // Forwarding priority (head = 1 here, so entries wrap)
        ld_valid = 1'b1; ld_addr = 5'd30; ld_data = 5'h0E;
        wr = 1'b1; addr = 5'd3; wdata = 5'h01;
        step();
        exp_push("fp_count1", S_COUNT, 1);
        wdata = 5'h1F;
        step();
        wr = 1'b0;
        exp_push("fp_count2", S_COUNT, 2);
        exp_push("fp_full",   S_FULL,  1);
        exp_push("fp_young",  S_RDATA, 'h1F);
        step();
        addr = 5'd30;
        exp_push("fp_loader", S_RDATA, 'h0E);
        exp_push("fp_hold",   S_COUNT, 2);
        step();
        ld_valid = 1'b0;
        addr = 5'd3;
        step();
        exp_push("fp_drain1", S_COUNT, 1);
        exp_push("fp_fwd1",   S_RDATA, 'h1F);
        step();
        exp_push("fp_drain2", S_COUNT, 0);
        exp_push("fp_mem",    S_RDATA, 'h1F);
        step();

        // Overflow
        ld_valid = 1'b1;
        wr = 1'b1; addr = 5'd1; wdata = 5'h11;
        step();
        addr = 5'd2; wdata = 5'h12;
        step();
        exp_push("ov_pre", S_OVF, 0);
        addr = 5'd4; wdata = 5'h14;
        step();
        wr = 1'b0;
        exp_push("ov_flag",  S_OVF,   1);
        exp_push("ov_count", S_COUNT, 2);
        exp_push("ov_rd4",   S_RDATA, 0);
        step();
        addr = 5'd2;
        exp_push("ov_rd2", S_RDATA, 'h12);
        ld_valid = 1'b0;
        step();
        step();
        addr = 5'd1;
        exp_push("ov_cnt0",   S_COUNT, 0);
        exp_push("ov_sticky", S_OVF,   1);
        exp_push("ov_mem1",   S_RDATA, 'h11);
        step();
        addr = 5'd4;
        exp_push("ov_mem4", S_RDATA, 0);
        step();

        // Loader versus queue ordering
        ld_valid = 1'b1; ld_addr = 5'd9; ld_data = 5'h15;
        wr = 1'b1; addr = 5'd9; wdata = 5'h0A;
        step();
        wr = 1'b0;
        ld_valid = 1'b0;
        exp_push("lq_count", S_COUNT, 1);
        exp_push("lq_fwd",   S_RDATA, 'h0A);
        step();
        exp_push("lq_count0", S_COUNT, 0);
        exp_push("lq_mem",    S_RDATA, 'h0A);
        step();

        // Async reset mid-operation
        ld_valid = 1'b1; ld_addr = 5'd30; ld_data = 5'h0E;
        wr = 1'b1; addr = 5'd6; wdata = 5'h06;
        step();
        addr = 5'd7; wdata = 5'h07;
        step();
        wr = 1'b0;
        addr = 5'd6;
        exp_push("ar_count2", S_COUNT, 2);
        exp_push("ar_fwd6",   S_RDATA, 'h06);
        @(negedge clock);
        #2;
        ld_valid = 1'b0;
        addr = 5'd30;
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        exp_push("ar_count", S_COUNT, 0);
        exp_push("ar_empty", S_EMPTY, 1);
        exp_push("ar_full",  S_FULL,  0);
        exp_push("ar_ovf",   S_OVF,   0);
        exp_push("ar_mem30", S_RDATA, 0);
        step();
        addr = 5'd9;
        exp_push("ar_mem9", S_RDATA, 0);
        step();
        wr = 1'b1; addr = 5'd5; wdata = 5'h13;
        step();
        wr = 1'b0;
        exp_push("ar_sl_count1", S_COUNT, 1);
        exp_push("ar_sl_fwd",    S_RDATA, 'h13);
        step();
        exp_push("ar_sl_count0", S_COUNT, 0);
        exp_push("ar_sl_mem",    S_RDATA, 'h13);
        step();

        for (int i = 0; i < 10 && q_sig.size() > 0; i++) begin
            step();
        end
        if (q_sig.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     q_sig.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
